// File: rtl/ariane_pkg.sv
// Shared frontend/execute types used by the branch predictors.
// cf_t classifies the control-flow instruction carried by a resolved-branch
// record; only Branch (conditional) trains the branch history table.
package ariane_pkg;

  typedef enum logic [2:0] {
    NoCF   = 3'd0,
    Branch = 3'd1,
    Jump   = 3'd2,
    JumpR  = 3'd3,
    Return = 3'd4
  } cf_t;

endpackage

// File: rtl/riscv.sv
// Architectural widths and the resolved-branch record sent from the execute
// stage branch unit back to the frontend predictors.
package riscv;

  localparam int unsigned VLEN = 64;

  typedef struct packed {
    logic              valid;
    logic [VLEN-1:0]   pc;
    logic [VLEN-1:0]   target_address;
    logic              is_mispredict;
    logic              is_taken;
    ariane_pkg::cf_t   cf_type;
  } bp_resolve_t;

endpackage

// File: rtl/branch_history_table.sv
// branch_history_table
//   Table of 2-bit saturating direction counters indexed by branch PC.
//   The execute stage trains it with resolved conditional branches; the
//   frontend reads a taken/not-taken prediction for the current fetch PC.
//   After reset or flush a sweep clears one entry per cycle (state CLEAR);
//   lookups report invalid and training is dropped until the sweep ends.
//
// Ports
//   clk_i              clock
//   rst_ni             synchronous reset, active-low
//   flush_i            restart the clear sweep
//   vpc_i              fetch PC to look up (combinational lookup)
//   resolved_branch_i  resolved-branch record from the branch unit
//   bht_valid_o        lookup hit on a trained entry
//   bht_taken_o        predicted direction (counter MSB)
//   busy_o             clear sweep in progress
//
// Update interface: resolved_branch_i is a fire-and-forget record. It is
// consumed on the rising edge when valid is high; there is no ready signal,
// so a record that arrives while the sweep runs is simply lost.
module branch_history_table #(
  parameter int unsigned NR_ENTRIES = 1024,
  parameter int unsigned ROW_OFFSET = 1
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    flush_i,
  input  logic [riscv::VLEN-1:0]  vpc_i,
  input  riscv::bp_resolve_t      resolved_branch_i,
  output logic                    bht_valid_o,
  output logic                    bht_taken_o,
  output logic                    busy_o
);

  localparam int unsigned IDX_W = $clog2(NR_ENTRIES);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NR_ENTRIES - 1);

  typedef enum logic {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } state_t;

  state_t           state;
  state_t           state_next;
  logic [IDX_W-1:0] clr_idx;
  logic [IDX_W-1:0] clr_idx_next;

  // Table storage: no reset, the sweep initialises it.
  logic             valid_q [NR_ENTRIES];
  logic [1:0]       ctr_q   [NR_ENTRIES];

  logic [IDX_W-1:0] lk_idx;
  logic [IDX_W-1:0] upd_idx;
  logic             upd_en;
  logic [1:0]       upd_ctr;
  logic             sweep_we;

  // Upper PC bits and the BTB/mispredict fields are intentionally ignored.
  logic             unused_bits;
  assign unused_bits = ^{vpc_i, resolved_branch_i};

  assign lk_idx  = vpc_i[ROW_OFFSET +: IDX_W];
  assign upd_idx = resolved_branch_i.pc[ROW_OFFSET +: IDX_W];

  // ---------------------------------------------------------------- state reg
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state   <= CLEAR;
      clr_idx <= '0;
    end else begin
      state   <= state_next;
      clr_idx <= clr_idx_next;
    end
  end

  // --------------------------------------------------------------- next state
  always_comb begin
    state_next   = state;
    clr_idx_next = clr_idx;
    if (flush_i) begin
      // Flush in any state (including mid-sweep) restarts from entry 0.
      state_next   = CLEAR;
      clr_idx_next = '0;
    end else begin
      unique case (state)
        CLEAR: begin
          clr_idx_next = clr_idx + 1'b1;
          if (clr_idx == LAST_IDX) begin
            state_next = RUN;
          end
        end
        RUN: begin
          state_next = RUN;
        end
        default: begin
          state_next = CLEAR;
        end
      endcase
    end
  end

  // ------------------------------------------------------------------ outputs
  always_comb begin
    busy_o      = !rst_ni || (state == CLEAR);
    sweep_we    = rst_ni && (state == CLEAR);
    upd_en      = rst_ni && (state == RUN) && resolved_branch_i.valid &&
                  (resolved_branch_i.cf_type == ariane_pkg::Branch);
    bht_valid_o = rst_ni && (state == RUN) && valid_q[lk_idx];
    bht_taken_o = bht_valid_o && ctr_q[lk_idx][1];
  end

  // Next counter value for the trained entry. A first sighting lands on the
  // weak state of the observed direction; afterwards saturate at 00 / 11.
  always_comb begin
    upd_ctr = ctr_q[upd_idx];
    if (!valid_q[upd_idx]) begin
      upd_ctr = resolved_branch_i.is_taken ? 2'b10 : 2'b01;
    end else if (resolved_branch_i.is_taken) begin
      if (ctr_q[upd_idx] != 2'b11) begin
        upd_ctr = ctr_q[upd_idx] + 2'b01;
      end
    end else begin
      if (ctr_q[upd_idx] != 2'b00) begin
        upd_ctr = ctr_q[upd_idx] - 2'b01;
      end
    end
  end

  // -------------------------------------------------------------- table write
  // Lookups read the registered contents, so a write is seen one cycle later.
  always_ff @(posedge clk_i) begin
    if (sweep_we) begin
      valid_q[clr_idx] <= 1'b0;
      ctr_q[clr_idx]   <= 2'b01;
    end else if (upd_en) begin
      valid_q[upd_idx] <= 1'b1;
      ctr_q[upd_idx]   <= upd_ctr;
    end
  end

endmodule

// File: tb/tb_branch_history_table.sv
// Testbench for branch_history_table: directed and randomized training and
// lookups checked against a table model, plus a 4-entry instance for aliasing.
module tb_branch_history_table;

  localparam int N    = 1024;
  localparam int RO   = 1;
  localparam int VLEN = riscv::VLEN;

  // ------------------------------------------------------ clock / reset block
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic               rst_n;
  logic               flush;
  logic [VLEN-1:0]    vpc;
  riscv::bp_resolve_t rb;
  logic               valid_o, taken_o, busy_o;

  logic               flush4;
  logic [VLEN-1:0]    vpc4;
  riscv::bp_resolve_t rb4;
  logic               valid4, taken4, busy4;

  branch_history_table #(.NR_ENTRIES(N), .ROW_OFFSET(RO)) dut (
    .clk_i             (clk),
    .rst_ni            (rst_n),
    .flush_i           (flush),
    .vpc_i             (vpc),
    .resolved_branch_i (rb),
    .bht_valid_o       (valid_o),
    .bht_taken_o       (taken_o),
    .busy_o            (busy_o)
  );

  branch_history_table #(.NR_ENTRIES(4), .ROW_OFFSET(1)) dut4 (
    .clk_i             (clk),
    .rst_ni            (rst_n),
    .flush_i           (flush4),
    .vpc_i             (vpc4),
    .resolved_branch_i (rb4),
    .bht_valid_o       (valid4),
    .bht_taken_o       (taken4),
    .busy_o            (busy4)
  );

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  // ------------------------------------------------------------ reference model
  int n_assert = 0;
  int n_fail   = 0;

  bit m_valid [N];
  int m_ctr   [N];
  int sweep_left;

  logic [VLEN-1:0] trained_q [$];

  function automatic int idx_of(input logic [VLEN-1:0] pc);
    return int'((pc >> RO) % N);
  endfunction

  function automatic logic [VLEN-1:0] rand64();
    return {$urandom, $urandom};
  endfunction

  // Applies what the table should do with the inputs present at this edge.
  task automatic model_edge();
    int i;
    if (!rst_n || flush) begin
      sweep_left = N;
      foreach (m_valid[k]) m_valid[k] = 1'b0;
    end else if (sweep_left > 0) begin
      sweep_left--;
    end else if (rb.valid && rb.cf_type == ariane_pkg::Branch) begin
      i = idx_of(rb.pc);
      if (!m_valid[i]) begin
        m_valid[i] = 1'b1;
        m_ctr[i]   = rb.is_taken ? 2 : 1;
      end else if (rb.is_taken) begin
        m_ctr[i] = (m_ctr[i] >= 3) ? 3 : m_ctr[i] + 1;
      end else begin
        m_ctr[i] = (m_ctr[i] <= 0) ? 0 : m_ctr[i] - 1;
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  // ------------------------------------------------------------- scoreboard
  task automatic chk(input string tag, input logic got, input logic exp);
    n_assert++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, got, exp);
    end
  endtask

  task automatic chk_int(input string tag, input int got, input int exp);
    n_assert++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic check_outputs(input string tag);
    int  i;
    bit  eb, ev, et;
    i  = idx_of(vpc);
    eb = !rst_n || (sweep_left > 0);
    ev = !eb && m_valid[i];
    et = ev && (m_ctr[i] >= 2);
    chk({tag, "_busy"},  busy_o,  eb);
    chk({tag, "_valid"}, valid_o, ev);
    chk({tag, "_taken"}, taken_o, et);
  endtask

  // ------------------------------------------------------------ driver tasks
  task automatic lookup(input logic [VLEN-1:0] pc, input string tag);
    vpc = pc;
    #1;
    check_outputs(tag);
  endtask

  // Presents one resolved record together with a lookup, checks the
  // pre-edge outputs, then lets the edge consume the record.
  task automatic upd(input logic [VLEN-1:0] pc, input bit taken,
                     input ariane_pkg::cf_t cf, input logic [VLEN-1:0] look_pc,
                     input string tag);
    rb.valid          = 1'b1;
    rb.pc             = pc;
    rb.target_address = rand64();
    rb.is_mispredict  = 1'($urandom_range(0, 1));
    rb.is_taken       = taken;
    rb.cf_type        = cf;
    lookup(look_pc, tag);
    tick();
    rb.valid = 1'b0;
  endtask

  task automatic rand_record(input logic [VLEN-1:0] pc);
    rb.valid          = ($urandom_range(0, 4) != 0);
    rb.pc             = pc;
    rb.target_address = rand64();
    rb.is_mispredict  = 1'($urandom_range(0, 1));
    rb.is_taken       = 1'($urandom_range(0, 1));
    rb.cf_type        = ($urandom_range(0, 3) == 0) ?
                        ariane_pkg::cf_t'($urandom_range(0, 4)) : ariane_pkg::Branch;
  endtask

  // ---------------------------------------------------------------- stimulus
  initial begin
    int cnt;
    int cnt4;
    logic [VLEN-1:0] pc;
    logic [VLEN-1:0] pool [8];

    rst_n  = 1'b0;
    flush  = 1'b0;
    flush4 = 1'b0;
    vpc    = '0;
    rb     = '0;
    vpc4   = '0;
    rb4    = '0;
    pool   = '{64'h0, 64'h2, 64'h10, 64'h7fe, 64'h100, 64'h102, 64'h3c4, 64'h6aa};

    // Reset held for a few cycles.
    repeat (3) tick();
    lookup(rand64(), "reset");
    chk("reset_busy4",  busy4,  1'b1);
    chk("reset_valid4", valid4, 1'b0);

    // Release reset: sweep lasts exactly N cycles, lookups stay invalid.
    rst_n = 1'b1;
    cnt   = 0;
    cnt4  = 0;
    while (busy_o === 1'b1 && cnt < 3 * N) begin
      lookup(rand64(), "init_sweep");
      if (busy4 === 1'b1) cnt4++;
      tick();
      cnt++;
    end
    chk_int("init_sweep_len",  cnt,  N);
    chk_int("init_sweep_len4", cnt4, 4);
    for (int k = 0; k < 16; k++) begin
      lookup(rand64(), "post_reset");
      chk("post_reset_invalid", valid_o, 1'b0);
    end

    // Train one branch: taken, then not-taken until saturation at 00.
    pc = 64'h8000_0010;
    upd(pc, 1'b1, ariane_pkg::Branch, pc, "br1_t");
    lookup(pc, "br1_after_t");
    chk("br1_t_valid", valid_o, 1'b1);
    chk("br1_t_taken", taken_o, 1'b1);
    upd(pc, 1'b0, ariane_pkg::Branch, pc, "br1_nt1");
    upd(pc, 1'b0, ariane_pkg::Branch, pc, "br1_nt2");
    lookup(pc, "br1_after_nt2");
    chk("br1_nt2_taken", taken_o, 1'b0);
    upd(pc, 1'b0, ariane_pkg::Branch, pc, "br1_nt3");
    lookup(pc, "br1_sat_low");
    upd(pc, 1'b1, ariane_pkg::Branch, pc, "br1_t_after_sat");
    lookup(pc, "br1_from_00");
    chk("br1_from_00_taken", taken_o, 1'b0);

    // Four taken at 0x100: same-cycle lookup sees the old (invalid) entry.
    pc = 64'h100;
    rb.valid = 1'b1; rb.pc = pc; rb.is_taken = 1'b1; rb.cf_type = ariane_pkg::Branch;
    vpc = pc;
    #1;
    chk("same_cycle_valid", valid_o, 1'b0);
    check_outputs("same_cycle");
    tick();
    rb.valid = 1'b0;
    lookup(pc, "t4_1");
    chk("t4_1_taken", taken_o, 1'b1);
    for (int k = 0; k < 3; k++) upd(pc, 1'b1, ariane_pkg::Branch, pc, "t4_n");
    lookup(pc, "t4_sat_high");
    upd(pc, 1'b0, ariane_pkg::Branch, pc, "t4_nt1");
    lookup(pc, "t4_from_11");
    chk("t4_from_11_taken", taken_o, 1'b1);
    upd(pc, 1'b0, ariane_pkg::Branch, pc, "t4_nt2");
    lookup(pc, "t4_to_01");

    // Non-branch control flow and invalid records never train.
    pc = 64'h200;
    upd(pc, 1'b1, ariane_pkg::JumpR,  pc, "cf_jumpr");
    upd(pc, 1'b1, ariane_pkg::Return, pc, "cf_return");
    upd(pc, 1'b1, ariane_pkg::Jump,   pc, "cf_jump");
    upd(pc, 1'b1, ariane_pkg::NoCF,   pc, "cf_nocf");
    rb.valid = 1'b0; rb.pc = pc; rb.cf_type = ariane_pkg::Branch;
    tick();
    lookup(pc, "cf_after");
    chk("cf_untrained", valid_o, 1'b0);

    // Randomized training and lookups over an aliasing PC pool.
    for (int k = 0; k < 400; k++) begin
      pc = (rand64() & ~64'h7ff) | pool[$urandom_range(0, 7)];
      rand_record(pc);
      lookup((rand64() & ~64'h7ff) | pool[$urandom_range(0, 7)], "rand");
      tick();
    end
    rb.valid = 1'b0;

    // Train 10 entries, then flush; updates during the sweep are dropped.
    for (int k = 0; k < 10; k++) begin
      pc = 64'h400 + 64'(2 * k);
      trained_q.push_back(pc);
      upd(pc, 1'b1, ariane_pkg::Branch, pc, "train10");
    end
    foreach (trained_q[k]) lookup(trained_q[k], "trained");
    flush = 1'b1;
    lookup(trained_q[0], "flush_edge");
    tick();
    flush = 1'b0;
    for (int k = 0; k < 5; k++) begin
      rand_record(trained_q[$urandom_range(0, 9)]);
      lookup(trained_q[$urandom_range(0, 9)], "sweep_a");
      tick();
    end
    flush = 1'b1;
    lookup(trained_q[1], "reflush_edge");
    tick();
    flush = 1'b0;
    cnt = 0;
    while (busy_o === 1'b1 && cnt < 3 * N) begin
      rand_record(trained_q[$urandom_range(0, 9)]);
      lookup(trained_q[$urandom_range(0, 9)], "sweep_b");
      tick();
      cnt++;
    end
    rb.valid = 1'b0;
    chk_int("flush_sweep_len", cnt, N);
    foreach (trained_q[k]) begin
      lookup(trained_q[k], "after_flush");
      chk("after_flush_invalid", valid_o, 1'b0);
    end

    // 4-entry instance: 0x0 and 0x8 share index 0.
    rb4.valid = 1'b1; rb4.pc = 64'h0; rb4.is_taken = 1'b1; rb4.cf_type = ariane_pkg::Branch;
    tick();
    rb4.valid = 1'b0;
    vpc4 = 64'h8;
    #1;
    chk("alias4_valid", valid4, 1'b1);
    chk("alias4_taken", taken4, 1'b1);
    vpc4 = 64'h2;
    #1;
    chk("alias4_other_invalid", valid4, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
